// File: rtl/hub75_blank_scheduler.sv
// HUB75 bit-plane on-time controller: guard blanking, then a BCM window of
// BASE_CYCLES << bit whose LED-on part is scaled by a frame-synchronous brightness.
module hub75_blank_scheduler #(
    parameter int unsigned BASE_CYCLES     = 32,
    parameter int unsigned GUARD_CYCLES    = 4,
    parameter int unsigned BIT_W           = 3,
    parameter int unsigned INIT_BRIGHTNESS = 255
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIT_W-1:0] bit_in,
    input  logic             frame_start,
    input  logic [7:0]       brightness_in,
    input  logic             brightness_we,
    output logic             blank,
    output logic             busy,
    output logic             done,
    output logic [7:0]       active_brightness,
    output logic             overrun
);

    localparam int unsigned W_MAX   = BASE_CYCLES << ((1 << BIT_W) - 1);
    localparam int unsigned CNT_MAX = (W_MAX > GUARD_CYCLES) ? W_MAX : GUARD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_ON,
        ST_OFF,
        ST_END
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] on_t_q;
    logic [CNT_W-1:0] off_t_q;
    logic [7:0]       pending;
    logic             deferred;

    logic [CNT_W-1:0] w_new;
    logic [CNT_W-1:0] on_t_new;
    logic [CNT_W+7:0] prod;
    logic [7:0]       eff_pending;
    logic             enter_end;

    always_comb begin
        w_new       = CNT_W'(BASE_CYCLES) << bit_in;
        prod        = (CNT_W + 8)'(w_new) * (CNT_W + 8)'(active_brightness);
        on_t_new    = (active_brightness == 8'hFF) ? w_new : CNT_W'(prod >> 8);
        eff_pending = brightness_we ? brightness_in : pending;
        // Last busy cycle of the window: the next edge lands in ST_END.
        enter_end   = (cnt == '0) &&
                      (((state == ST_ON) && (off_t_q == '0)) || (state == ST_OFF));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            on_t_q            <= '0;
            off_t_q           <= '0;
            blank             <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            overrun           <= 1'b0;
            active_brightness <= 8'(INIT_BRIGHTNESS);
            pending           <= 8'(INIT_BRIGHTNESS);
            deferred          <= 1'b0;
        end else begin
            pending <= eff_pending;
            done    <= 1'b0;

            if (start && busy)
                overrun <= 1'b1;

            // Brightness only changes while no window is being displayed.
            if (frame_start && !busy) begin
                active_brightness <= eff_pending;
            end else if (enter_end && (frame_start || deferred)) begin
                active_brightness <= eff_pending;
                deferred          <= 1'b0;
            end else if (frame_start) begin
                deferred <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_END: begin
                    if (start) begin
                        on_t_q  <= on_t_new;
                        off_t_q <= w_new - on_t_new;
                        busy    <= 1'b1;
                        if (GUARD_CYCLES != 0) begin
                            state <= ST_GUARD;
                            cnt   <= CNT_W'(GUARD_CYCLES - 1);
                            blank <= 1'b1;
                        end else if (on_t_new != '0) begin
                            state <= ST_ON;
                            cnt   <= on_t_new - 1'b1;
                            blank <= 1'b0;
                        end else begin
                            state <= ST_OFF;
                            cnt   <= w_new - 1'b1;
                            blank <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        blank <= 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt == '0) begin
                        if (on_t_q != '0) begin
                            state <= ST_ON;
                            cnt   <= on_t_q - 1'b1;
                            blank <= 1'b0;
                        end else begin
                            state <= ST_OFF;
                            cnt   <= off_t_q - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt == '0) begin
                        blank <= 1'b1;
                        if (off_t_q == '0) begin
                            state <= ST_END;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_OFF;
                            cnt   <= off_t_q - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt == '0) begin
                        state <= ST_END;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    blank <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_blank_scheduler.sv
// Bench for hub75_blank_scheduler: time-indexed window model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hub75_blank_scheduler;

    localparam int BASE = 32;
    localparam int G    = 4;
    localparam int INIT = 255;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] bit_in = '0;
    logic       frame_start = 1'b0;
    logic [7:0] brightness_in = '0;
    logic       brightness_we = 1'b0;
    logic       blank;
    logic       busy;
    logic       done;
    logic [7:0] active_brightness;
    logic       overrun;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    hub75_blank_scheduler #(
        .BASE_CYCLES(BASE),
        .GUARD_CYCLES(G),
        .BIT_W(3),
        .INIT_BRIGHTNESS(INIT)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .start(start),
        .bit_in(bit_in),
        .frame_start(frame_start),
        .brightness_in(brightness_in),
        .brightness_we(brightness_we),
        .blank(blank),
        .busy(busy),
        .done(done),
        .active_brightness(active_brightness),
        .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: a window is described by the cycle index n since acceptance (n=1 is
    // the first cycle after the accepting edge), its length W and on-time ON.
    bit m_win = 0;
    int m_n = 0, m_w = 0, m_on = 0;
    int m_act = INIT, m_pend = INIT;
    bit m_defer = 0, m_ovr = 0;

    always @(posedge sys_clk) begin
        int  eff;
        bit  cur_busy, enter_end;
        if (rst) begin
            m_win = 0; m_n = 0; m_ovr = 0; m_defer = 0;
            m_act = INIT; m_pend = INIT;
        end else begin
            eff       = brightness_we ? int'(brightness_in) : m_pend;
            cur_busy  = m_win && (m_n <= G + m_w);
            enter_end = m_win && (m_n == G + m_w);
            if (start && cur_busy) m_ovr = 1;
            if (start && !cur_busy) begin
                m_w   = BASE << bit_in;
                m_on  = (m_act == 255) ? m_w : (m_w * m_act) / 256;
                m_win = 1;
                m_n   = 1;
            end else if (m_win) begin
                m_n++;
                if (m_n > G + m_w + 1) m_win = 0;
            end
            if (frame_start && !cur_busy) m_act = eff;
            else if (enter_end && (frame_start || m_defer)) begin
                m_act = eff; m_defer = 0;
            end else if (frame_start) m_defer = 1;
            m_pend = eff;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("busy", busy, int'(m_win && m_n <= G + m_w));
            check("blank", blank, int'(!(m_win && m_n > G && m_n <= G + m_on)));
            check("done", done, int'(m_win && m_n == G + m_w + 1));
            check("active_brightness", active_brightness, m_act);
            check("overrun", overrun, int'(m_ovr));
        end
    end

    // Pulse start with bit b, then watch until done or limit cycles. At cycle
    // act_cyc apply: 1=extra start, 2=write val then frame_start 5 cycles later,
    // 3=frame_start, 4=rst.
    task automatic window(input int b, input int act_cyc, input int kind, input int val,
                          input int limit, output int busy_n, output int low_n,
                          output int done_at, output int act_pre, output int act_end);
        @(negedge sys_clk);
        start = 1; bit_in = 3'(b);
        busy_n = 0; low_n = 0; done_at = 0; act_pre = -1; act_end = -1;
        for (int t = 1; t <= limit && done_at == 0; t++) begin
            @(negedge sys_clk);
            start = 0; brightness_we = 0; frame_start = 0; rst = 0;
            if (busy) busy_n++;
            if (!blank) low_n++;
            if (done) begin
                done_at = t; act_end = active_brightness;
            end else act_pre = active_brightness;
            if (t == act_cyc) begin
                case (kind)
                    1: start = 1;
                    2: begin brightness_we = 1; brightness_in = 8'(val); end
                    3: frame_start = 1;
                    4: rst = 1;
                    default: ;
                endcase
            end
            if (kind == 2 && t == act_cyc + 5) frame_start = 1;
        end
        start = 0; brightness_we = 0; frame_start = 0; rst = 0;
    endtask

    task automatic set_brightness(input int v);
        @(negedge sys_clk);
        brightness_we = 1; brightness_in = 8'(v); frame_start = 1;
        @(negedge sys_clk);
        brightness_we = 0; frame_start = 0;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        int bn, ln, da, ap, ae, r;
        repeat (3) @(negedge sys_clk);
        rst = 0;
        chk_en = 1;
        check("rst_blank", blank, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_active", active_brightness, 255);

        // Full brightness, plane 0.
        window(0, 0, 0, 0, 200, bn, ln, da, ap, ae);
        check("t1_busy_cycles", bn, 36);
        check("t1_blank_low", ln, 32);
        check("t1_done_at", da, 37);

        // Half brightness, plane 3.
        set_brightness(128);
        check("t2_active", active_brightness, 128);
        window(3, 0, 0, 0, 400, bn, ln, da, ap, ae);
        check("t2_busy_cycles", bn, 260);
        check("t2_blank_low", ln, 128);
        check("t2_done_at", da, 261);

        // Zero brightness, longest plane.
        set_brightness(0);
        window(7, 0, 0, 0, 5000, bn, ln, da, ap, ae);
        check("t3_busy_cycles", bn, 4100);
        check("t3_blank_low", ln, 0);
        check("t3_done_at", da, 4101);

        // Overrun from a start mid-window.
        set_brightness(255);
        window(1, 10, 1, 0, 200, bn, ln, da, ap, ae);
        check("t4_busy_cycles", bn, 68);
        check("t4_blank_low", ln, 64);
        check("t4_done_at", da, 69);
        check("t4_overrun", overrun, 1);

        // Deferred brightness change.
        repeat (2) @(negedge sys_clk);
        window(0, 8, 2, 64, 200, bn, ln, da, ap, ae);
        check("t5_active_before_end", ap, 255);
        check("t5_active_at_end", ae, 64);
        check("t5_overrun_held", overrun, 1);
        window(2, 0, 0, 0, 300, bn, ln, da, ap, ae);
        check("t5_busy_cycles", bn, 132);
        check("t5_blank_low", ln, 32);

        // Reset in the ON phase.
        set_brightness(255);
        set_brightness(128);
        window(0, 10, 4, 0, 40, bn, ln, da, ap, ae);
        check("t6_busy_cycles", bn, 10);
        check("t6_blank_low", ln, 6);
        check("t6_no_done", da, 0);
        check("t6_active", active_brightness, 255);
        check("t6_overrun", overrun, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            @(negedge sys_clk);
            start         = ($urandom_range(0, 39) == 0);
            bit_in        = 3'($urandom_range(0, 4));
            frame_start   = ($urandom_range(0, 29) == 0);
            brightness_we = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 9);
            brightness_in = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : (r == 2) ? 8'd1
                          : 8'($urandom_range(0, 255));
            rst           = ($urandom_range(0, 2999) == 0);
        end
        @(negedge sys_clk);
        start = 0; frame_start = 0; brightness_we = 0; rst = 0;
        repeat (5) @(negedge sys_clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hub75_blank_scheduler.md
Name: hub75_blank_scheduler

Overview:
Bit-plane on-time controller for the HUB75 panel path, in the sys_clk domain. After the row data is latched, the row sequencer starts it with the bit-plane index. It then drives blank for a guard period followed by a binary-code-modulation window of (BASE_CYCLES << bit). Within that window the LED-on portion is scaled by a global 8-bit brightness. A new brightness value takes effect only at a frame boundary, so a frame is never shown with mixed brightness.

Parameters:
BASE_CYCLES, 32, sys_clk cycles in the window for bit plane 0; must be >= 1.
GUARD_CYCLES, 4, blank-high dead time after start, for anti-ghosting; 0 is allowed.
BIT_W, 3, width of the bit-plane index.
INIT_BRIGHTNESS, 255, brightness value loaded at reset.

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that starts a display window; accepted only while busy=0
bit_in  in  BIT_W  bit-plane index, sampled together with start
frame_start  in  1  one-cycle pulse marking a frame boundary
brightness_in  in  8  new brightness value
brightness_we  in  1  loads brightness_in into the pending register
blank  out  1  panel blank (1 = LEDs off)
busy  out  1  window in progress
done  out  1  one-cycle pulse at the end of a window
active_brightness  out  8  brightness currently applied
overrun  out  1  sticky; set when start arrives while busy=1

Behaviour:
- Reset values: blank=1, busy=0, done=0, overrun=0, active_brightness=INIT_BRIGHTNESS, pending=INIT_BRIGHTNESS, state=IDLE.
- A reset asserted mid-window aborts the window: blank=1 and busy=0 on the next cycle, and no done pulse is produced.
- Window length W = BASE_CYCLES << bit. Size the counters for bit = 2^BIT_W - 1.
- On-time ON_T = (active_brightness == 255) ? W : (W * active_brightness) >> 8.
  - Truncating multiply, full-width product, no overflow.
  - ON_T is latched at start, using the bit and brightness values present on that cycle.
- States and transitions:
  - IDLE: start=1 (sampled at edge k) -> GUARD, or directly to ON if GUARD_CYCLES=0. busy=1 from cycle k+1.
  - GUARD: blank=1 for GUARD_CYCLES cycles -> ON. If ON_T=0, go to OFF instead.
  - ON: blank=0 for ON_T cycles -> OFF. If ON_T=W, go straight to END.
  - OFF: blank=1 for W-ON_T cycles -> END.
  - END: done=1 and busy=0 for one cycle, blank=1 -> IDLE.
  - A start on the END cycle is accepted, equivalent to being accepted from IDLE.
- Cycle count: busy is high for exactly GUARD_CYCLES + W cycles, independent of brightness, so frame rate does not depend on brightness.
- blank is registered and glitch-free. It falls at most once per window.
- A start while busy=1 is ignored (the window is not restarted) and sets overrun. overrun clears only on rst.
- Brightness update:
  - brightness_we loads pending on the next edge.
  - frame_start in IDLE/END copies pending to active_brightness on the next edge.
  - frame_start while busy sets a deferred flag. The copy then happens on the END cycle and the flag clears.
  - brightness_we and frame_start on the same cycle: the new brightness_in value is the one applied (write-through).
  - start and frame_start on the same cycle in IDLE: the window uses the old active value, and the new value applies from the next window.
- Brightness 0: blank is never low, but the window timing is unchanged.

Test Plan:
1. Reset, then start with bit_in=0 and default parameters -> busy high for 36 cycles, blank low for cycles 5..36 after start (32 cycles), done pulse on cycle 37.
2. brightness_we with 128 and frame_start, then start with bit_in=3 -> W=256, blank low for exactly 128 cycles, busy high for 260 cycles.
3. brightness 0, start with bit_in=7 -> blank stays 1 for the whole window, busy high for 4100 cycles, done pulses once.
4. Second start pulsed mid-window -> window length unchanged, overrun=1 and held until rst.
5. brightness_we with 64 during a busy window, frame_start while busy -> active_brightness stays 255 until the END cycle, then becomes 64; the next window with bit_in=2 has blank low for 32 cycles.
6. rst asserted during ON -> next cycle blank=1 and busy=0, no done pulse, active_brightness=255.
